// File: rtl/uart_rx.sv
// uart_rx: UART receive front end with a built-in 16x oversampling baud tick.
//   Synchronizes rx, validates the start bit at mid-bit, then samples DBIT
//   data bits LSB first (plus an even-parity bit when UART_RX_PARITY_EN is
//   defined) and checks the stop bit. rx_done_tick pulses for one clk with
//   dout valid; the error flags describe that frame and hold until the next
//   rx_done_tick.
// Optional feature macro: UART_RX_PARITY_EN (PARITY state and parity_err).
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   rx           in   asynchronous serial input, idles high
//   rx_done_tick out  one-clk pulse, frame received
//   dout         out  received word [DBIT-1:0]
//   frame_err    out  stop bit sampled low in the last frame
//   parity_err   out  parity mismatch in the last frame (0 without parity)
//   s_tick       out  oversampling tick, one clk wide
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned DVSR    = 163,
  parameter int unsigned DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err,
  output logic            s_tick
);

  localparam int unsigned S_W = $clog2(SB_TICK);
  localparam int unsigned N_W = $clog2(DBIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // Two-flop synchronizer; both stages reset to the idle (high) level.
  logic r_sync1;
  logic r_rx_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_rx_sync <= r_sync1;
    end
  end

  // Baud generator: free-running 0..DVSR-1, tick on the terminal count.
  logic [DVSR_W-1:0] r_div;
  logic              w_tick;

  assign w_tick = (r_div == DVSR_W'(DVSR - 1));
  assign s_tick = w_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DVSR_W'(1);
    end
  end

  state_t           r_state, w_state_nxt;
  logic [S_W-1:0]   r_s, w_s_nxt;
  logic [N_W-1:0]   r_n, w_n_nxt;
  logic [DBIT-1:0]  r_b, w_b_nxt;
  logic             w_done_nxt;
  logic             r_done;
  logic [DBIT-1:0]  r_dout;
  logic             r_ferr;

`ifdef UART_RX_PARITY_EN
  logic             r_p_bad, w_p_bad_nxt;
  logic             r_perr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_done  <= 1'b0;
      r_dout  <= '0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_p_bad <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_done  <= w_done_nxt;
`ifdef UART_RX_PARITY_EN
      r_p_bad <= w_p_bad_nxt;
`endif
      // Output word and flags are captured on the stop-bit sample tick, so
      // they appear together with rx_done_tick one clk later.
      if (w_done_nxt) begin
        r_dout <= r_b;
        r_ferr <= ~r_rx_sync;
`ifdef UART_RX_PARITY_EN
        r_perr <= r_p_bad;
`endif
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_done_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_p_bad_nxt = r_p_bad;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_sync) begin
          w_state_nxt = ST_START;
          w_s_nxt     = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_s == S_W'(7)) begin
            w_s_nxt = '0;
            if (!r_rx_sync) begin
              w_state_nxt = ST_DATA;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_nxt = r_s + S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_s == S_W'(15)) begin
            w_s_nxt = '0;
            w_b_nxt = {r_rx_sync, r_b[DBIT-1:1]};
            if (r_n == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end else begin
              w_n_nxt = r_n + N_W'(1);
            end
          end else begin
            w_s_nxt = r_s + S_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          if (r_s == S_W'(15)) begin
            w_s_nxt     = '0;
            w_p_bad_nxt = r_rx_sync ^ (^r_b);
            w_state_nxt = ST_STOP;
          end else begin
            w_s_nxt = r_s + S_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (r_s == S_W'(SB_TICK - 1)) begin
            w_s_nxt     = '0;
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_s_nxt = r_s + S_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_s_nxt     = '0;
      end
    endcase
  end

  assign rx_done_tick = r_done;
  assign dout         = r_dout;
  assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-frame bench for uart_rx with DVSR=4 (64 clk per bit).
// Stimulus pushes the expected word/flags into a queue when a frame is sent;
// an independent monitor pops and compares on every rx_done_tick.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;
  logic       parity_err;
  logic       s_tick;

  always #5 clk = ~clk;

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16),
    .DVSR    (4),
    .DVSR_W  (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .s_tick       (s_tick)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_done_tick) begin
        check("done_one_clk", {31'b0, prev}, 32'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got dout=%0h expected no frame", dout);
        end else begin
          e = q.pop_front();
          check("dout", {24'b0, dout}, {24'b0, e.d});
          check("frame_err", {31'b0, frame_err}, {31'b0, e.fe});
          check("parity_err", {31'b0, parity_err}, {31'b0, e.pe});
        end
      end
      prev = rx_done_tick;
    end
  end

  task automatic send_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic idle(input int clks);
    send_bit(1'b1, clks);
  endtask

  // A bad stop bit is held low only long enough to cover its mid-bit sample,
  // so the line is back high before the receiver could re-validate a start.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                            input logic par_flip);
    exp_t e;
    e.d  = d;
    e.fe = ~stop_ok;
`ifdef UART_RX_PARITY_EN
    e.pe = par_flip;
`else
    e.pe = 1'b0;
`endif
    q.push_back(e);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip, BIT_CLKS);
`endif
    if (stop_ok) begin
      send_bit(1'b1, BIT_CLKS);
    end else begin
      send_bit(1'b0, 40);
      send_bit(1'b1, BIT_CLKS - 40);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, {31'b0, rx_done_tick}, 32'd0);
    check({tag, "_dout"}, {24'b0, dout}, 32'h00);
    check({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
    check({tag, "_parity_err"}, {31'b0, parity_err}, 32'd0);
  endtask

  initial begin : stim
    int         ticks;
    logic [7:0] v99;
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset");

    // Idle line: no frames, tick every 4th clk
    ticks = 0;
    repeat (1000) begin
      @(negedge clk);
      if (s_tick) ticks++;
    end
    check("s_tick_count", ticks, 250);
    check_reset_outputs("idle");

    // Good frame
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(BIT_CLKS);

    // Framing error, flag holds, then clears on a good frame
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(2 * BIT_CLKS);
    check("frame_err_hold", {31'b0, frame_err}, 32'd1);
    send_frame(8'h01, 1'b1, 1'b0);
    idle(BIT_CLKS);

    // Start-bit glitch (5 ticks) then a good frame
    send_bit(1'b0, 20);
    idle(2 * BIT_CLKS);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(BIT_CLKS);

    // Back-to-back frames, parity corrupted on the last
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(2 * BIT_CLKS);

    // Reset in the middle of data bit 4 of 0x99; the sender aborts too
    v99 = 8'h99;
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) send_bit(v99[i], BIT_CLKS);
    send_bit(v99[4], BIT_CLKS / 2);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(3 * BIT_CLKS);
    check_reset_outputs("midreset");

    send_frame(8'h42, 1'b1, 1'b0);
    idle(2 * BIT_CLKS);

    check("frames_outstanding", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive front end with an integrated 16x oversampling baud-tick generator. It synchronizes the asynchronous `rx` line, detects and validates a start bit, and samples DBIT data bits LSB-first at mid-bit. It then checks the stop bit and pulses `rx_done_tick` with the received word on `dout`. It sits directly upstream of the receive FIFO: `rx_done_tick` drives the FIFO `wr` and `dout` drives the FIFO `w_data`.

## Interface
- `DBIT`, 8: data bits per frame; legal range 5..9.
- `SB_TICK`, 16: oversampling ticks for the stop bit; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- `DVSR`, 163: clk cycles per oversampling tick (f_clk / (16 × baud)); must be ≥ 2.
- `DVSR_W`, 8: width of the divider counter; requires 2^DVSR_W ≥ DVSR.
- `clk`  in  1  system clock; one clock domain; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `rx_done_tick`  out  1  one-clk pulse: a frame has been received and `dout` is valid.
- `dout`  out  DBIT  received word; held until the next `rx_done_tick`.
- `frame_err`  out  1  stop bit sampled low in the frame just completed.
- `parity_err`  out  1  parity mismatch in the frame just completed; constant 0 when parity is compiled out.
- `s_tick`  out  1  baud oversampling tick, one clk wide; exported for a companion transmitter.

## Operation
- Synchronizer: two flops in series (`rx` → `rx_sync`), both reset to 1. All FSM decisions use `rx_sync`.
- Baud generator: counter `0..DVSR-1`, free-running, reset to 0. `s_tick` = 1 when the counter equals `DVSR-1`, then the counter wraps to 0.
- Tick counter `s`:
  - width clog2(SB_TICK).
  - Counts only on `s_tick` cycles.
  - Cleared on every state entry.
- Bit counter `n`: width clog2(DBIT). Shift register `b`: DBIT bits wide.
- IDLE: when `rx_sync` = 0, go to START with `s` = 0. No tick is required for this transition.
- START: on a tick with `s` = 7:
  - if `rx_sync` = 0, go to DATA with `s` = 0 and `n` = 0;
  - otherwise the start bit was a glitch: go to IDLE with no output.
  - On other ticks, `s` increments.
- DATA: on a tick with `s` = 15:
  - `s` = 0 and `b` = {`rx_sync`, `b[DBIT-1:1]`}, so data is shifted in LSB first.
  - If `n` = DBIT-1, go to PARITY when parity is enabled, otherwise STOP. Otherwise `n` increments.
- PARITY (only when UART_RX_PARITY_EN is defined): on a tick with `s` = 15, latch `p_bad` = `rx_sync` XOR (XOR-reduce `b`), i.e. even parity, then go to STOP.
- STOP: on a tick with `s` = SB_TICK-1, go to IDLE. In the next clk:
  - `rx_done_tick` = 1;
  - `dout` ← `b`;
  - `frame_err` ← NOT `rx_sync` (as sampled on that tick);
  - `parity_err` ← `p_bad`.
- Errors do not suppress `rx_done_tick`. The downstream logic qualifies the data with the error flags. Overrun is handled by the FIFO (it drops writes when full).
- `frame_err` and `parity_err` hold their values until the next `rx_done_tick` updates them.

## Timing
- Reset values: state IDLE; all counters 0; `rx_done_tick` 0; `dout` 0; `frame_err` 0; `parity_err` 0; `s_tick` 0; both synchronizer flops 1.
- Reset taken mid-frame: the block returns to IDLE on the next clk, the partial frame is discarded, and no `rx_done_tick` is issued.
- Sampling points:
  - The start bit is validated 8 ticks after the falling edge is detected (its mid-bit).
  - Each following bit is sampled 16 ticks later.
  - The stop bit is sampled SB_TICK ticks after the last data or parity sample.
- Latency:
  - `rx_done_tick` is registered and asserts exactly 1 clk after the STOP-completing `s_tick` cycle.
  - From a falling edge on `rx`, detection takes 2 clk of synchronizer delay plus 1 clk for the IDLE → START transition.
- Back-to-back frames: the FSM returns to IDLE in the same cycle that `rx_done_tick` is scheduled, so a start bit immediately following the stop bit is accepted.
- `rx_done_tick` is never high for 2 consecutive clk.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is present; one even-parity bit follows the data bits; `parity_err` is reported per frame.
- `UART_RX_PARITY_EN` undefined: no PARITY state; DATA goes directly to STOP; `parity_err` is tied to 0.

## Test plan
Benches use DVSR=4, so one bit period = 64 clk.
- Reset, then `rx` = 1 for 1000 clk → `rx_done_tick` stays 0, `dout` = 0x00, both error flags 0; `s_tick` pulses every 4th clk.
- Frame 0xA5 (start 0; data 1,0,1,0,0,1,0,1; stop 1) → exactly one `rx_done_tick`; `dout` = 0xA5; `frame_err` = 0.
- Frame 0x3C with the stop bit driven 0 → `rx_done_tick` = 1; `dout` = 0x3C; `frame_err` = 1. A following good frame 0x01 → `frame_err` returns to 0.
- Low pulse of 20 clk (5 ticks) on an idle line → no `rx_done_tick`; the FSM is back in IDLE. A following frame 0x55 is received correctly.
- Frames 0x00, 0xFF, 0x81 sent back-to-back with no idle gap → three `rx_done_tick` pulses with `dout` 0x00, 0xFF, 0x81 in order. With parity enabled, corrupting the parity bit of 0x81 → `parity_err` = 1.
- `reset` asserted for 1 clk in the middle of data bit 4 of frame 0x99 → no `rx_done_tick`; outputs remain at their reset values. The next frame 0x42 → `dout` = 0x42.
